// File: rtl/hazard_pkg.sv
// Shared encodings and limits for the load-use hazard scoreboard.
// Imported by the per-register timer and the scoreboard top.
package hazard_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_LU   = 2'b01,
        CAUSE_MEM  = 2'b10,
        CAUSE_BOTH = 2'b11
    } stall_cause_e;

    // Countdown width per register; it bounds the legal load latency.
    localparam int TIMER_W      = 3;
    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = (1 << TIMER_W) - 1;

    function automatic stall_cause_e make_cause(input logic mem_busy, input logic lu);
        return stall_cause_e'({mem_busy, lu});
    endfunction

endpackage

// File: rtl/hazard_reg_timer.sv
// Countdown for one architectural register: reload on load issue, count
// down while the pipeline moves, freeze while memory is busy.
module hazard_reg_timer
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic hold_i,
    output logic busy_o
);

    logic [TIMER_W-1:0] timer_q, timer_d;

    // NOTE: timer_d gets its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        timer_d = timer_q;
        if (load_i) begin
            timer_d = TIMER_W'(LOAD_LAT);
        end else if (!hold_i && timer_q != '0) begin
            timer_d = timer_q - TIMER_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign busy_o = (timer_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: one countdown per register, combinational
// stall/cause generation and a saturating stalled-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ID_valid,
    input  logic [REG_AW-1:0]        ID_rs_addr,
    input  logic                     ID_rs_used,
    input  logic [REG_AW-1:0]        ID_rt_addr,
    input  logic                     ID_rt_used,
    input  logic                     ID_mem_read,
    input  logic [REG_AW-1:0]        ID_wr_addr,
    input  logic                     flush,
    input  logic                     mem_busy,
    output logic                     stall,
    output logic [1:0]               stall_cause,
    output logic [(1<<REG_AW)-1:0]   busy_regs,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int NUM_REGS = 1 << REG_AW;

    logic [NUM_REGS-1:0] busy_w;
    logic [NUM_REGS-1:0] load_vec;
    logic                rs_hit, rt_hit, lu, issue;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    // Register 0 is hardwired when ZERO_REG is set, so it can never be a producer.
    assign rs_hit = ID_rs_used && busy_w[ID_rs_addr] && !(ZERO_REG && ID_rs_addr == '0);
    assign rt_hit = ID_rt_used && busy_w[ID_rt_addr] && !(ZERO_REG && ID_rt_addr == '0);
    assign lu     = ID_valid && (rs_hit || rt_hit);

    assign stall       = lu || mem_busy;
    assign stall_cause = make_cause(mem_busy, lu);
    assign issue       = ID_valid && !stall && !flush;

    always_comb begin
        load_vec = '0;
        if (issue && ID_mem_read && !(ZERO_REG && ID_wr_addr == '0)) begin
            load_vec[ID_wr_addr] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_timer
        hazard_reg_timer #(
            .LOAD_LAT (LOAD_LAT)
        ) u_timer (
            .clk    (clk),
            .rst    (rst),
            .load_i (load_vec[g]),
            .hold_i (mem_busy),
            .busy_o (busy_w[g])
        );
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy_regs = busy_w;
    assign stall_cnt = stall_cnt_q;

endmodule
